// File: rtl/mackerel_bus_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mackerel_bus_pkg
// Brief    : Shared bus-cycle state encoding, port-size codes and default waits
// Revision : 1.0 - initial release
// ============================================================================
package mackerel_bus_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_WAIT    = 3'd1,
    ST_DUART   = 3'd2,
    ST_IDE_SU  = 3'd3,
    ST_IDE_STB = 3'd4,
    ST_ACK     = 3'd5,
    ST_BERR    = 3'd6
  } bus_state_t;

  typedef enum logic [1:0] {
    PS_NONE  = 2'd0,
    PS_8BIT  = 2'd1,
    PS_16BIT = 2'd2,
    PS_32BIT = 2'd3
  } port_size_t;

  localparam int unsigned c_rom_wait     = 3;
  localparam int unsigned c_sram_wait    = 0;
  localparam int unsigned c_ide_setup    = 2;
  localparam int unsigned c_ide_strobe   = 6;
  localparam int unsigned c_berr_timeout = 255;

  // Returns {DSACK1_n, DSACK0_n} for an acknowledged port size.
  function automatic logic [1:0] dsack_n_for(input port_size_t ps);
    logic [1:0] v;
    v = 2'b11;
    case (ps)
      PS_8BIT:  v = 2'b10;
      PS_16BIT: v = 2'b01;
      PS_32BIT: v = 2'b00;
      default:  v = 2'b11;
    endcase
    return v;
  endfunction

endpackage
`default_nettype wire

// File: rtl/bus_watchdog.sv
`default_nettype none
// ============================================================================
// Module   : bus_watchdog
// Brief    : Saturating 8-bit cycle counter flagging a stalled bus cycle
// Revision : 1.0 - initial release
// ============================================================================
module bus_watchdog
  import mackerel_bus_pkg::*;
#(
  parameter logic [7:0] TIMEOUT = 8'(c_berr_timeout)
) (
  input  logic CLK,
  input  logic RST,
  input  logic run,
  input  logic clear,
  output logic timeout
);

  logic [7:0] r_count;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_count <= '0;
    end else if (clear) begin
      r_count <= '0;
    end else if (run && (r_count != 8'hFF)) begin
      r_count <= r_count + 8'd1;
    end
  end

  assign timeout = (r_count >= TIMEOUT);

endmodule
`default_nettype wire

// File: rtl/dsack_generator.sv
`default_nettype none
// ============================================================================
// Module   : dsack_generator
// Brief    : Bus-cycle FSM producing DSACK/BERR and IDE strobes per decoded select
// Revision : 1.0 - initial release
// ============================================================================
module dsack_generator
  import mackerel_bus_pkg::*;
#(
  parameter int unsigned ROM_WAIT     = c_rom_wait,
  parameter int unsigned SRAM_WAIT    = c_sram_wait,
  parameter int unsigned IDE_SETUP    = c_ide_setup,
  parameter int unsigned IDE_STROBE   = c_ide_strobe,
  parameter int unsigned BERR_TIMEOUT = c_berr_timeout
) (
  input  logic CLK,
  input  logic RST,
  input  logic AS_n,
  input  logic DS_n,
  input  logic RW,
  input  logic CS_ROM_n,
  input  logic CS_SRAM_n,
  input  logic CS_DUART_n,
  input  logic IACK_DUART_n,
  input  logic IDE_CS0_n,
  input  logic IDE_CS1_n,
  input  logic DTACK_DUART_n,
  input  logic IDE_RDY,
  output logic DSACK0_n,
  output logic DSACK1_n,
  output logic BERR_n,
  output logic IDE_RD_n,
  output logic IDE_WR_n
);

  bus_state_t r_state, w_next;
  port_size_t r_size, w_size_next;
  logic [7:0] r_count, w_count_next;
  logic       r_as_low;
  logic       w_timeout;
  logic       w_wd_run;
  logic       w_stb_active;

  assign w_wd_run = ~AS_n & (r_state != ST_ACK);

  bus_watchdog #(
    .TIMEOUT (8'(BERR_TIMEOUT))
  ) u_watchdog (
    .CLK     (CLK),
    .RST     (RST),
    .run     (w_wd_run),
    .clear   (AS_n),
    .timeout (w_timeout)
  );

  // r_as_low blocks a new cycle start until AS_n has been seen high once.
  always_comb begin
    w_next       = r_state;
    w_count_next = r_count;
    w_size_next  = r_size;
    if (AS_n) begin
      w_next       = ST_IDLE;
      w_count_next = '0;
      w_size_next  = PS_NONE;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (!r_as_low) begin
            if (!IDE_CS0_n || !IDE_CS1_n) begin
              w_next       = ST_IDE_SU;
              w_count_next = 8'(IDE_SETUP - 1);
              w_size_next  = PS_16BIT;
            end else if (!CS_DUART_n || !IACK_DUART_n) begin
              w_next      = ST_DUART;
              w_size_next = PS_8BIT;
            end else if (!CS_ROM_n) begin
              w_next       = ST_WAIT;
              w_count_next = 8'(ROM_WAIT);
              w_size_next  = PS_8BIT;
            end else if (!CS_SRAM_n) begin
              w_next       = ST_WAIT;
              w_count_next = 8'(SRAM_WAIT);
              w_size_next  = PS_32BIT;
            end
          end else if (w_timeout) begin
            w_next = ST_BERR;
          end
        end
        ST_WAIT: begin
          if (r_count == 8'd0) begin
            w_next = ST_ACK;
          end else if (w_timeout) begin
            w_next = ST_BERR;
          end else begin
            w_count_next = r_count - 8'd1;
          end
        end
        ST_DUART: begin
          if (!DTACK_DUART_n) begin
            w_next = ST_ACK;
          end else if (w_timeout) begin
            w_next = ST_BERR;
          end
        end
        ST_IDE_SU: begin
          if (w_timeout) begin
            w_next = ST_BERR;
          end else if (r_count == 8'd0) begin
            w_next       = ST_IDE_STB;
            w_count_next = 8'(IDE_STROBE);
          end else begin
            w_count_next = r_count - 8'd1;
          end
        end
        ST_IDE_STB: begin
          if ((r_count == 8'd0) && IDE_RDY) begin
            w_next = ST_ACK;
          end else if (w_timeout) begin
            w_next = ST_BERR;
          end else if (r_count != 8'd0) begin
            w_count_next = r_count - 8'd1;
          end
        end
        default: begin
          w_next = r_state;
        end
      endcase
    end
  end

  // Strobe rises one edge after IDE_STB entry and survives into ACK.
  assign w_stb_active = (r_size == PS_16BIT) &&
                        ((r_state == ST_IDE_STB) || (r_state == ST_ACK)) &&
                        ((w_next == ST_IDE_STB) || (w_next == ST_ACK));

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_state  <= ST_IDLE;
      r_size   <= PS_NONE;
      r_count  <= '0;
      r_as_low <= 1'b0;
      DSACK0_n <= 1'b1;
      DSACK1_n <= 1'b1;
      BERR_n   <= 1'b1;
      IDE_RD_n <= 1'b1;
      IDE_WR_n <= 1'b1;
    end else begin
      r_state  <= w_next;
      r_size   <= w_size_next;
      r_count  <= w_count_next;
      r_as_low <= ~AS_n;
      {DSACK1_n, DSACK0_n} <= (w_next == ST_ACK) ? dsack_n_for(w_size_next) : 2'b11;
      BERR_n   <= ~(w_next == ST_BERR);
      IDE_RD_n <= ~(w_stb_active & RW);
      // A write strobe only asserts once DS_n is low; afterwards it holds.
      IDE_WR_n <= ~(w_stb_active & ~RW & (~IDE_WR_n | ~DS_n));
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_dsack_generator.sv
`default_nettype none
// ============================================================================
// Module   : tb_dsack_generator
// Brief    : Directed self-checking bench for dsack_generator
// Revision : 1.0 - initial release
// ============================================================================
module tb_dsack_generator;

  logic CLK = 1'b0;
  logic RST;
  logic AS_n, DS_n, RW;
  logic CS_ROM_n, CS_SRAM_n, CS_DUART_n, IACK_DUART_n;
  logic IDE_CS0_n, IDE_CS1_n, DTACK_DUART_n, IDE_RDY;
  logic DSACK0_n, DSACK1_n, BERR_n, IDE_RD_n, IDE_WR_n;
  logic [4:0] outs;

  int n_checks = 0;
  int n_errors = 0;

  // outs = {DSACK1_n, DSACK0_n, BERR_n, IDE_RD_n, IDE_WR_n}
  localparam logic [4:0] c_quiet = 5'b11111;
  localparam logic [4:0] c_ack8  = 5'b10111;
  localparam logic [4:0] c_ack32 = 5'b00111;
  localparam logic [4:0] c_berr  = 5'b11011;
  localparam logic [4:0] c_rd    = 5'b11101;
  localparam logic [4:0] c_rdack = 5'b01101;
  localparam logic [4:0] c_wr    = 5'b11110;
  localparam logic [4:0] c_wrack = 5'b01110;

  assign outs = {DSACK1_n, DSACK0_n, BERR_n, IDE_RD_n, IDE_WR_n};

  always #5 CLK = ~CLK;

  dsack_generator #(
    .ROM_WAIT     (3),
    .SRAM_WAIT    (0),
    .IDE_SETUP    (2),
    .IDE_STROBE   (6),
    .BERR_TIMEOUT (255)
  ) dut (
    .CLK           (CLK),
    .RST           (RST),
    .AS_n          (AS_n),
    .DS_n          (DS_n),
    .RW            (RW),
    .CS_ROM_n      (CS_ROM_n),
    .CS_SRAM_n     (CS_SRAM_n),
    .CS_DUART_n    (CS_DUART_n),
    .IACK_DUART_n  (IACK_DUART_n),
    .IDE_CS0_n     (IDE_CS0_n),
    .IDE_CS1_n     (IDE_CS1_n),
    .DTACK_DUART_n (DTACK_DUART_n),
    .IDE_RDY       (IDE_RDY),
    .DSACK0_n      (DSACK0_n),
    .DSACK1_n      (DSACK1_n),
    .BERR_n        (BERR_n),
    .IDE_RD_n      (IDE_RD_n),
    .IDE_WR_n      (IDE_WR_n)
  );

  task automatic check(input string tag, input logic [4:0] got, input logic [4:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %b expected %b (DSACK1,DSACK0,BERR,RD,WR)", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  task automatic bus_idle();
    AS_n = 1'b1; DS_n = 1'b1; RW = 1'b1;
    CS_ROM_n = 1'b1; CS_SRAM_n = 1'b1; CS_DUART_n = 1'b1; IACK_DUART_n = 1'b1;
    IDE_CS0_n = 1'b1; IDE_CS1_n = 1'b1; DTACK_DUART_n = 1'b1; IDE_RDY = 1'b0;
  endtask

  task automatic release_bus(input string tag);
    AS_n = 1'b1;
    DS_n = 1'b1;
    step(1);
    check(tag, outs, c_quiet);
    bus_idle();
    step(1);
  endtask

  initial begin
    bus_idle();
    RST = 1'b1;
    step(2);
    check("reset_outputs", outs, c_quiet);
    RST = 1'b0;
    step(2);
    check("idle_after_reset", outs, c_quiet);

    // ROM read: W=3, acknowledge at N+4, 8-bit port
    AS_n = 1'b0; CS_ROM_n = 1'b0; RW = 1'b1; DS_n = 1'b0;
    step(1);
    check("rom_edge_n", outs, c_quiet);
    step(3);
    check("rom_n3", outs, c_quiet);
    step(1);
    check("rom_ack_n4", outs, c_ack8);
    step(2);
    check("rom_ack_hold", outs, c_ack8);
    release_bus("rom_release");

    // SRAM write: W=0, acknowledge at N+1, 32-bit port
    AS_n = 1'b0; CS_SRAM_n = 1'b0; RW = 1'b0; DS_n = 1'b0;
    step(1);
    check("sram_edge_n", outs, c_quiet);
    step(1);
    check("sram_ack_n1", outs, c_ack32);
    release_bus("sram_release");

    // IDE read, IDE_RDY low for 10 edges
    AS_n = 1'b0; IDE_CS0_n = 1'b0; RW = 1'b1; DS_n = 1'b0; IDE_RDY = 1'b0;
    step(3);
    check("ide_rd_n2_no_strobe", outs, c_quiet);
    step(1);
    check("ide_rd_strobe_n3", outs, c_rd);
    step(7);
    check("ide_rd_wait_n10", outs, c_rd);
    IDE_RDY = 1'b1;
    step(1);
    check("ide_rd_ack_n11", outs, c_rdack);
    release_bus("ide_rd_release");

    // IDE write: DS_n late gates strobe; minimum width forces ack at N+9
    AS_n = 1'b0; IDE_CS1_n = 1'b0; RW = 1'b0; DS_n = 1'b1; IDE_RDY = 1'b1;
    step(5);
    check("ide_wr_ds_gate_n4", outs, c_quiet);
    DS_n = 1'b0;
    step(1);
    check("ide_wr_strobe_n5", outs, c_wr);
    step(3);
    check("ide_wr_min_width_n8", outs, c_wr);
    step(1);
    check("ide_wr_ack_n9", outs, c_wrack);
    release_bus("ide_wr_release");

    // Unmapped access: bus error at N+255
    AS_n = 1'b0; DS_n = 1'b0;
    step(1);
    step(254);
    check("unmapped_n254", outs, c_quiet);
    step(1);
    check("unmapped_berr_n255", outs, c_berr);
    step(1);
    check("unmapped_berr_hold", outs, c_berr);
    release_bus("berr_release");

    // DUART IACK: DTACK low after 5 edges
    AS_n = 1'b0; IACK_DUART_n = 1'b0; RW = 1'b1; DTACK_DUART_n = 1'b1;
    step(6);
    check("iack_wait_n5", outs, c_quiet);
    DTACK_DUART_n = 1'b0;
    step(1);
    check("iack_ack", outs, c_ack8);
    release_bus("iack_release");

    // DTACK and watchdog on the same edge: acknowledge wins
    AS_n = 1'b0; CS_DUART_n = 1'b0; DTACK_DUART_n = 1'b1;
    step(255);
    check("duart_slow_n254", outs, c_quiet);
    DTACK_DUART_n = 1'b0;
    step(1);
    check("ack_beats_timeout", outs, c_ack8);
    release_bus("ack_timeout_release");

    // Priority: IDE beats ROM (ROM would ack at N+4)
    AS_n = 1'b0; IDE_CS0_n = 1'b0; CS_ROM_n = 1'b0; RW = 1'b1; IDE_RDY = 1'b0;
    step(5);
    check("prio_ide_over_rom", outs, c_rd);
    release_bus("prio_ide_release");

    // Priority: DUART beats ROM
    AS_n = 1'b0; CS_DUART_n = 1'b0; CS_ROM_n = 1'b0; DTACK_DUART_n = 1'b1;
    step(5);
    check("prio_duart_over_rom", outs, c_quiet);
    DTACK_DUART_n = 1'b0;
    step(1);
    check("prio_duart_ack", outs, c_ack8);
    release_bus("prio_duart_release");

    // Abort mid IDE_STB: strobe released on the same edge
    AS_n = 1'b0; IDE_CS0_n = 1'b0; RW = 1'b1; IDE_RDY = 1'b0;
    step(6);
    check("abort_strobe_on", outs, c_rd);
    AS_n = 1'b1;
    step(1);
    check("abort_released", outs, c_quiet);
    IDE_RDY = 1'b1;
    step(2);
    check("abort_stays_idle", outs, c_quiet);
    bus_idle();
    step(1);

    // Reset pulse mid IDE_STB: outputs clear asynchronously
    AS_n = 1'b0; IDE_CS0_n = 1'b0; RW = 1'b1; IDE_RDY = 1'b0;
    step(6);
    check("rst_strobe_on", outs, c_rd);
    #2 RST = 1'b1;
    #1 check("rst_async_clear", outs, c_quiet);
    AS_n = 1'b1; IDE_RDY = 1'b1;
    step(1);
    RST = 1'b0;
    step(3);
    check("rst_no_late_ack", outs, c_quiet);

    // New cycle after reset works normally
    AS_n = 1'b0; IDE_CS0_n = 1'b1; CS_SRAM_n = 1'b0; RW = 1'b1;
    step(2);
    check("post_rst_sram_ack", outs, c_ack32);
    release_bus("post_rst_release");

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
